// File: rtl/fc_pkg.sv
// Shared definitions for the fully connected layer sequencer: the FSM
// state encoding and the width helpers used to size addresses and the
// accumulator.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fc_state_t;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Address width, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Accumulator holds LENGTH full-width products plus one bit of headroom.
  function automatic int acc_width(input int bitwidth, input int length);
    return 2 * bitwidth + clog2(length) + 1;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Signed multiply-accumulate register. The accumulator clears or adds one
// product per enabled cycle; total is the running sum including the current
// product plus the sign-extended bias, truncated to the result width.
module fc_mac
  import fc_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int ACCW     = acc_width(8, 25)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      en,
  input  logic                      bias_cap,
  input  logic signed [BITWIDTH-1:0] a,
  input  logic signed [BITWIDTH-1:0] b,
  input  logic signed [BITWIDTH-1:0] bias,
  output logic [2*BITWIDTH-1:0]      total
);

  logic signed [2*BITWIDTH-1:0] a_ext;
  logic signed [2*BITWIDTH-1:0] b_ext;
  logic signed [2*BITWIDTH-1:0] prod;
  logic signed [ACCW-1:0]       prod_ext;
  logic signed [ACCW-1:0]       acc_reg;
  logic signed [ACCW-1:0]       acc_next;
  logic signed [BITWIDTH-1:0]   bias_reg;
  logic signed [BITWIDTH-1:0]   bias_sel;

  // Operands are widened first so the product is exact in 2*BITWIDTH bits.
  assign a_ext    = {{BITWIDTH{a[BITWIDTH-1]}}, a};
  assign b_ext    = {{BITWIDTH{b[BITWIDTH-1]}}, b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACCW-2*BITWIDTH){prod[2*BITWIDTH-1]}}, prod};
  assign acc_next = acc_reg + prod_ext;

  // The bias word is only on the bus during the capture cycle, so use it
  // directly then and the held copy afterwards.
  assign bias_sel = bias_cap ? bias : bias_reg;
  assign total    = acc_next[2*BITWIDTH-1:0] + {{BITWIDTH{bias_sel[BITWIDTH-1]}}, bias_sel};

  // Accumulator and bias holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg  <= '0;
      bias_reg <= '0;
    end else begin
      if (clr) begin
        acc_reg <= '0;
      end else if (en) begin
        acc_reg <= acc_next;
      end
      if (bias_cap) begin
        bias_reg <= bias;
      end
    end
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Time-multiplexed fully connected layer controller: walks each neuron's
// inputs through one MAC, one element per cycle, and streams the per-neuron
// results out over a valid/ready handshake.
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter  int BITWIDTH    = 8,
  parameter  int LENGTH      = 25,
  parameter  int FILTERBATCH = 1,
  localparam int DAW         = addr_width(LENGTH),
  localparam int WAW         = addr_width(LENGTH * FILTERBATCH),
  localparam int BAW         = addr_width(FILTERBATCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                rd_en,
  output logic [DAW-1:0]      data_addr,
  output logic [WAW-1:0]      weight_addr,
  output logic [BAW-1:0]      bias_addr,
  input  logic [BITWIDTH-1:0] data_in,
  input  logic [BITWIDTH-1:0] weight_in,
  input  logic [BITWIDTH-1:0] bias_in,
  output logic [2*BITWIDTH-1:0] result,
  output logic [BAW-1:0]      result_idx,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                done
);

  localparam int             ACCW   = acc_width(BITWIDTH, LENGTH);
  localparam logic [DAW-1:0] J_LAST = DAW'(LENGTH - 1);
  localparam logic [BAW-1:0] F_LAST = BAW'(FILTERBATCH - 1);

  fc_state_t              state_reg;
  logic                   start_ok;
  logic                   handshake;
  logic                   last_neuron;
  logic                   mac_clr;
  logic                   mac_en;
  logic                   mac_bias_cap;
  logic [2*BITWIDTH-1:0]  mac_total;

  // start is ignored in the done cycle so a held start re-arms only after a
  // full IDLE cycle.
  assign start_ok    = (state_reg == IDLE) && start && !done;
  assign handshake   = result_valid && result_ready;
  assign last_neuron = (bias_addr == F_LAST);

  // The first FETCH cycle of a neuron has no read data yet; the last element
  // returns during DRAIN. bias_addr is constant per neuron, so bias data is
  // first valid one cycle after the first read.
  assign mac_clr      = start_ok || (handshake && !last_neuron);
  assign mac_en       = ((state_reg == FETCH) && (data_addr != '0)) || (state_reg == DRAIN);
  assign mac_bias_cap = (LENGTH == 1) ? (state_reg == DRAIN)
                                      : ((state_reg == FETCH) && (data_addr == DAW'(1)));

  fc_mac #(
    .BITWIDTH(BITWIDTH),
    .ACCW    (ACCW)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mac_clr),
    .en      (mac_en),
    .bias_cap(mac_bias_cap),
    .a       (data_in),
    .b       (weight_in),
    .bias    (bias_in),
    .total   (mac_total)
  );

  // Sequencer FSM with address counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      busy         <= 1'b0;
      rd_en        <= 1'b0;
      data_addr    <= '0;
      weight_addr  <= '0;
      bias_addr    <= '0;
      result       <= '0;
      result_idx   <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            state_reg   <= FETCH;
            busy        <= 1'b1;
            rd_en       <= 1'b1;
            data_addr   <= '0;
            weight_addr <= '0;
            bias_addr   <= '0;
          end
        end
        FETCH: begin
          if (data_addr == J_LAST) begin
            state_reg <= DRAIN;
            rd_en     <= 1'b0;
          end else begin
            data_addr   <= data_addr + DAW'(1);
            weight_addr <= weight_addr + WAW'(1);
          end
        end
        DRAIN: begin
          state_reg    <= OUT;
          result       <= mac_total;
          result_idx   <= bias_addr;
          result_valid <= 1'b1;
        end
        OUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (last_neuron) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              // weight_addr already points at the last element of this
              // neuron, so the next neuron's first weight is one further on.
              state_reg   <= FETCH;
              rd_en       <= 1'b1;
              data_addr   <= '0;
              weight_addr <= weight_addr + WAW'(1);
              bias_addr   <= bias_addr + BAW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: three instances (L4/FB3, L1/FB1,
// L4/FB1) with small buffer models; expected results are queued at stimulus
// time and popped by per-instance monitors on each accepted result.
module tb_fc_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks;
  int   errors;

  // Instance A: LENGTH=4, FILTERBATCH=3
  logic        a_start, a_busy, a_rd_en, a_ready, a_valid, a_done;
  logic [1:0]  a_daddr, a_baddr, a_idx;
  logic [3:0]  a_waddr;
  logic [7:0]  a_din, a_win, a_bin;
  logic [15:0] a_res;
  logic [7:0]  a_dmem [4];
  logic [7:0]  a_wmem [12];
  logic [7:0]  a_bmem [4];

  // Instance B: LENGTH=1, FILTERBATCH=1
  logic        b_start, b_busy, b_rd_en, b_ready, b_valid, b_done;
  logic [0:0]  b_daddr, b_waddr, b_baddr, b_idx;
  logic [7:0]  b_din, b_win, b_bin;
  logic [15:0] b_res;
  logic [7:0]  b_dmem [2];
  logic [7:0]  b_wmem [2];
  logic [7:0]  b_bmem [2];

  // Instance C: LENGTH=4, FILTERBATCH=1
  logic        c_start, c_busy, c_rd_en, c_ready, c_valid, c_done;
  logic [1:0]  c_daddr, c_waddr;
  logic [0:0]  c_baddr, c_idx;
  logic [7:0]  c_din, c_win, c_bin;
  logic [15:0] c_res;
  logic [7:0]  c_dmem [4];
  logic [7:0]  c_wmem [4];
  logic [7:0]  c_bmem [2];

  fc_layer_sequencer #(.BITWIDTH(8), .LENGTH(4), .FILTERBATCH(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .rd_en(a_rd_en),
    .data_addr(a_daddr), .weight_addr(a_waddr), .bias_addr(a_baddr),
    .data_in(a_din), .weight_in(a_win), .bias_in(a_bin),
    .result(a_res), .result_idx(a_idx), .result_valid(a_valid),
    .result_ready(a_ready), .done(a_done)
  );

  fc_layer_sequencer #(.BITWIDTH(8), .LENGTH(1), .FILTERBATCH(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .rd_en(b_rd_en),
    .data_addr(b_daddr), .weight_addr(b_waddr), .bias_addr(b_baddr),
    .data_in(b_din), .weight_in(b_win), .bias_in(b_bin),
    .result(b_res), .result_idx(b_idx), .result_valid(b_valid),
    .result_ready(b_ready), .done(b_done)
  );

  fc_layer_sequencer #(.BITWIDTH(8), .LENGTH(4), .FILTERBATCH(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .busy(c_busy), .rd_en(c_rd_en),
    .data_addr(c_daddr), .weight_addr(c_waddr), .bias_addr(c_baddr),
    .data_in(c_din), .weight_in(c_win), .bias_in(c_bin),
    .result(c_res), .result_idx(c_idx), .result_valid(c_valid),
    .result_ready(c_ready), .done(c_done)
  );

  // Synchronous-read buffers with one cycle of latency.
  always @(posedge clk) if (a_rd_en) begin
    a_din <= a_dmem[a_daddr]; a_win <= a_wmem[a_waddr]; a_bin <= a_bmem[a_baddr];
  end
  always @(posedge clk) if (b_rd_en) begin
    b_din <= b_dmem[b_daddr]; b_win <= b_wmem[b_waddr]; b_bin <= b_bmem[b_baddr];
  end
  always @(posedge clk) if (c_rd_en) begin
    c_din <= c_dmem[c_daddr]; c_win <= c_wmem[c_waddr]; c_bin <= c_bmem[c_baddr];
  end

  logic [15:0] a_q_res[$], b_q_res[$], c_q_res[$];
  int          a_q_idx[$], b_q_idx[$], c_q_idx[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic no_expect(input string name, input logic [31:0] got);
    checks++;
    errors++;
    $display("FAIL %s got result %0h expected no result", name, got);
  endtask

  // Monitor A: scoreboard pop on handshake, stability while stalled.
  logic        a_hold = 1'b0;
  logic [15:0] a_hold_res = '0;
  logic [1:0]  a_hold_idx = '0;
  int          a_done_cnt = 0;
  always @(negedge clk) begin
    if (a_done) a_done_cnt++;
    if (a_valid) begin
      chk("a_rd_en_in_out", a_rd_en, 0);
      if (a_hold) begin
        chk("a_stall_result", a_res, a_hold_res);
        chk("a_stall_idx", a_idx, a_hold_idx);
      end
      if (a_ready) begin
        if (a_q_res.size() == 0) no_expect("a_unexpected", a_res);
        else begin
          chk("a_result", a_res, a_q_res.pop_front());
          chk("a_idx", a_idx, a_q_idx.pop_front());
        end
      end
      a_hold     = !a_ready;
      a_hold_res = a_res;
      a_hold_idx = a_idx;
    end else begin
      a_hold = 1'b0;
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (b_valid && b_ready) begin
      chk("b_rd_en_in_out", b_rd_en, 0);
      if (b_q_res.size() == 0) no_expect("b_unexpected", b_res);
      else begin
        chk("b_result", b_res, b_q_res.pop_front());
        chk("b_idx", b_idx, b_q_idx.pop_front());
      end
    end
  end

  // Monitor C.
  always @(negedge clk) begin
    if (c_valid && c_ready) begin
      chk("c_rd_en_in_out", c_rd_en, 0);
      if (c_q_res.size() == 0) no_expect("c_unexpected", c_res);
      else begin
        chk("c_result", c_res, c_q_res.pop_front());
        chk("c_idx", c_idx, c_q_idx.pop_front());
      end
    end
  end

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0:       a_start = v;
      1:       b_start = v;
      default: c_start = v;
    endcase
  endtask

  // One-cycle start pulse; returns #1 into the first FETCH cycle (t+1).
  task automatic pulse_start(input int inst);
    @(posedge clk); #1;
    set_start(inst, 1'b1);
    @(posedge clk); #1;
    set_start(inst, 1'b0);
  endtask

  task automatic wait_done(input int inst, input string tag, output int cycles);
    logic d;
    cycles = 0;
    d = 1'b0;
    while (!d && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      d = (inst == 0) ? a_done : (inst == 1) ? b_done : c_done;
    end
    if (!d) begin
      checks++;
      errors++;
      $display("FAIL %s got no done expected done within 200 cycles", tag);
    end
  endtask

  task automatic load_c_basic();
    for (int i = 0; i < 4; i++) begin
      c_dmem[i] = 8'(i + 1);
      c_wmem[i] = 8'd1;
    end
    c_bmem[0] = 8'd5;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int seen;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b_dmem[i] = '0; b_wmem[i] = '0; b_bmem[i] = '0; c_bmem[i] = '0;
    end
    a_bmem[3] = '0;
    load_c_basic();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", c_busy, 0);
    chk("rst_rd_en", c_rd_en, 0);
    chk("rst_valid", c_valid, 0);
    chk("rst_done", c_done, 0);
    chk("rst_result", c_res, 0);
    chk("rst_idx", c_idx, 0);
    chk("rst_waddr", a_waddr, 0);
    chk("rst_baddr", a_baddr, 0);
    rst_n = 1'b1;

    // Basic sum with exact timing: valid at t+6, done at t+7
    c_q_res.push_back(16'h000F); c_q_idx.push_back(0);
    pulse_start(2);
    for (int k = 1; k <= 5; k++) begin
      chk("c_valid_early", c_valid, 0);
      @(posedge clk); #1;
    end
    chk("c_valid_t6", c_valid, 1);
    chk("c_busy_t6", c_busy, 1);
    @(posedge clk); #1;
    chk("c_done_t7", c_done, 1);
    chk("c_busy_t7", c_busy, 0);
    @(posedge clk); #1;
    chk("c_done_pulse", c_done, 0);

    // Signed wrap: 4 * (-128 * -128) = 65536 -> 0x0000, then bias -1 -> 0xFFFF
    for (int i = 0; i < 4; i++) begin
      c_dmem[i] = 8'h80; c_wmem[i] = 8'h80;
    end
    c_bmem[0] = 8'h00;
    c_q_res.push_back(16'h0000); c_q_idx.push_back(0);
    pulse_start(2);
    wait_done(2, "c_wrap0_done", cyc);
    chk("c_wrap0_cycles", cyc, 6);
    c_bmem[0] = 8'hFF;
    c_q_res.push_back(16'hFFFF); c_q_idx.push_back(0);
    pulse_start(2);
    wait_done(2, "c_wrapm1_done", cyc);
    chk("c_wrapm1_cycles", cyc, 6);

    // LENGTH=1: 7 * -2 + 3 = -11, valid at t+3
    b_dmem[0] = 8'd7; b_wmem[0] = 8'hFE; b_bmem[0] = 8'd3;
    b_q_res.push_back(16'hFFF5); b_q_idx.push_back(0);
    pulse_start(1);
    chk("b_valid_t1", b_valid, 0);
    @(posedge clk); #1;
    chk("b_valid_t2", b_valid, 0);
    @(posedge clk); #1;
    chk("b_valid_t3", b_valid, 1);
    @(posedge clk); #1;
    chk("b_done_t4", b_done, 1);

    // FILTERBATCH=3 with a 5-cycle stall on neuron 1
    for (int i = 0; i < 4; i++) begin
      a_dmem[i]     = 8'(i + 1);
      a_wmem[i]     = 8'd1;
      a_wmem[8 + i] = 8'hFF;
    end
    a_wmem[4] = 8'd2; a_wmem[5] = 8'd0; a_wmem[6] = 8'hFF; a_wmem[7] = 8'd3;
    a_bmem[0] = 8'd5; a_bmem[1] = 8'hFD; a_bmem[2] = 8'd100;
    a_q_res.push_back(16'h000F); a_q_idx.push_back(0);
    a_q_res.push_back(16'h0008); a_q_idx.push_back(1);
    a_q_res.push_back(16'h005A); a_q_idx.push_back(2);
    a_done_cnt = 0;
    pulse_start(0);
    seen = 0;
    for (int k = 0; k < 60 && seen == 0; k++) begin
      if (a_valid && a_idx == 2'd1) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("a_idx1_seen", seen, 1);
    a_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("a_valid_stalled", a_valid, 1);
    a_ready = 1'b1;
    wait_done(0, "a_done", cyc);
    repeat (3) @(posedge clk);
    #1;
    chk("a_done_count", a_done_cnt, 1);

    // Asynchronous reset mid-FETCH discards the neuron
    load_c_basic();
    pulse_start(2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", c_busy, 0);
    chk("arst_rd_en", c_rd_en, 0);
    chk("arst_daddr", c_daddr, 0);
    chk("arst_waddr", c_waddr, 0);
    chk("arst_result", c_res, 0);
    chk("arst_valid", c_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("arst_no_valid", c_valid, 0);
    end
    c_q_res.push_back(16'h000F); c_q_idx.push_back(0);
    pulse_start(2);
    wait_done(2, "c_after_rst_done", cyc);
    chk("c_after_rst_cycles", cyc, 6);

    // start held high: one layer per IDLE visit, ignored in the done cycle
    c_q_res.push_back(16'h000F); c_q_idx.push_back(0);
    c_q_res.push_back(16'h000F); c_q_idx.push_back(0);
    @(posedge clk); #1;
    c_start = 1'b1;
    wait_done(2, "c_held1_done", cyc);
    chk("c_held1_cycles", cyc, 7);
    chk("c_held_busy_done", c_busy, 0);
    @(posedge clk); #1;
    chk("c_held_busy_idle", c_busy, 0);
    @(posedge clk); #1;
    chk("c_held_busy_restart", c_busy, 1);
    wait_done(2, "c_held2_done", cyc);
    chk("c_held2_cycles", cyc, 6);
    c_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("c_held_stopped", c_busy, 0);

    chk("a_queue_empty", a_q_res.size(), 0);
    chk("b_queue_empty", b_q_res.size(), 0);
    chk("c_queue_empty", c_q_res.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
